adder_pipelined_nbit: RTL and testbench
=======================================

// Module: adder_pipelined_nbit
// PURPOSE
//  Parametrised, pipelined add/subtract unit. Splits BIT_WIDTH operands into
//  NUM_STAGES chunks and resolves one chunk carry per clock, for wide adds at
//  high clock rates. Valid/ready handshake on both sides; sits between operand
//  source and result consumer in the datapath.
// PARAMETERS
//  BIT_WIDTH   16  operand/sum width; must be a multiple of NUM_STAGES
//  NUM_STAGES  4   pipeline depth = number of chunks; CHUNK = BIT_WIDTH/NUM_STAGES
// PORTS
//  clk        in   1          system clock, rising edge
//  n_rst      in   1          asynchronous, active-low reset
//  in_valid   in   1          operands a, b, carry_in, mode valid this cycle
//  in_ready   out  1          unit accepts operands this cycle
//  a          in   BIT_WIDTH  operand A
//  b          in   BIT_WIDTH  operand B
//  carry_in   in   1          carry into bit 0 (ADD only)
//  mode       in   1          adder_pkg::op_t: OP_ADD=0, OP_SUB=1
//  out_valid  out  1          result fields valid
//  out_ready  in   1          consumer takes result this cycle
//  sum        out  BIT_WIDTH  result
//  carry_out  out  1          carry out of MSB (SUB: 1 = no borrow)
//  overflow   out  1          signed two's-complement overflow
// BEHAVIOUR
//  - Reset (n_rst=0, async): all stage valid bits, sum, carry_out, overflow = 0.
//    In-flight operations are discarded; first accept is allowed on the first
//    clk edge after deassertion.
//  - Accept: transfer when in_valid && in_ready. in_ready = out_ready || !out_valid.
//  - Global stall: when out_valid && !out_ready, every stage holds, including
//    data and valid bits. No bubble squeezing. Outputs stay stable while stalled.
//  - Latency: exactly NUM_STAGES clocks from accept to out_valid with no stall.
//    Throughput: 1 result per clock.
//  - Effective B: b when ADD, ~b when SUB. Effective cin: carry_in when ADD,
//    1'b1 when SUB (carry_in ignored).
//  - Stage k (0..NUM_STAGES-1) adds chunk k of A and effective B with the carry
//    registered from stage k-1 (stage 0 uses effective cin). It registers the
//    sum chunk, the chunk carry, and the chunk MSB carry-in.
//  - Operand skew: unused upper chunks of A/B ride in registers alongside.
//    Completed lower sum chunks are also carried forward. Registers for dead
//    chunks are not required.
//  - carry_out = carry out of bit BIT_WIDTH-1. overflow = carry into MSB XOR
//    carry out of MSB.
//  - Per-result fields (sum, carry_out, overflow, mode) stay aligned with their
//    valid bit through every stage. No cross-talk between in-flight operations.
//  - NUM_STAGES=1: a single registered stage with latency 1.
//  - BIT_WIDTH % NUM_STAGES != 0 or NUM_STAGES < 1: elaboration-time $error.
//  - Assertions: a, b, mode are never X/Z when in_valid=1. out_valid never
//    drops while stalled.
// STRUCTURE
//  - adder_pkg: typedef enum logic {OP_ADD, OP_SUB} op_t.
//  - Per-stage chunk add uses the existing combinational adder_nbit
//    (BIT_WIDTH=CHUNK), one instance per stage in a generate loop.
//  - Stage registers use a single flop style with async n_rst.
// TESTING (BIT_WIDTH=16, NUM_STAGES=4 unless noted)
//  1. Reset: assert n_rst=0 mid-stream with 3 ops in flight -> out_valid=0,
//     sum=0 immediately. After release, nothing stale emerges.
//  2. ADD 16'hFFFF + 16'h0001, cin=0 -> 4 clks later: sum=16'h0000,
//     carry_out=1, overflow=0. Ripple crosses all 4 chunks.
//  3. ADD 16'h7FFF + 16'h0001 -> sum=16'h8000, carry_out=0, overflow=1.
//     SUB 16'h8000 - 16'h0001 -> sum=16'h7FFF, carry_out=1, overflow=1.
//  4. SUB 16'h0003 - 16'h0005, carry_in=1 (ignored) -> sum=16'hFFFE,
//     carry_out=0, overflow=0.
//  5. Back-to-back stream of 20 random ADD/SUB ops. Hold out_ready=0 for 5
//     clks mid-stream -> in_ready=0 while out_valid, outputs stable, all 20
//     results in order and match the reference model.
//  6. Parameter sweep (8,1), (32,8), (12,3): directed cases 2-4 scaled to
//     width, plus random; latency == NUM_STAGES.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the add/subtract datapath: operation select and
// operand-B conditioning for subtraction.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Subtraction is A + ~B + 1, so B is inverted and the carry forced high.
    function automatic logic eff_carry_in(input op_t op, input logic carry_in);
        return (op == OP_SUB) ? 1'b1 : carry_in;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Combinational N-bit ripple adder; also exposes the carry into its MSB so
// callers can derive signed overflow.
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 msb_carry_in
);

    logic [BIT_WIDTH:0] full;

    assign full         = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
    assign sum          = full[BIT_WIDTH-1:0];
    assign carry_out    = full[BIT_WIDTH];
    // sum bit = a ^ b ^ cin, so the carry into the MSB falls out directly.
    assign msb_carry_in = sum[BIT_WIDTH-1] ^ a[BIT_WIDTH-1] ^ b[BIT_WIDTH-1];

endmodule

// File: rtl/adder_pipelined_nbit.sv
// Pipelined add/subtract: one CHUNK-wide slice of the carry chain is resolved
// per stage, with a global stall driven by the output handshake.
module adder_pipelined_nbit
    import adder_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  op_t                  mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int STAGES = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
    localparam int CHUNK  = BIT_WIDTH / STAGES;

    if ((NUM_STAGES < 1) || (BIT_WIDTH % STAGES != 0)) begin : g_param_check
        $error("adder_pipelined_nbit: BIT_WIDTH must be a multiple of NUM_STAGES >= 1");
    end

    logic                 advance;
    logic [BIT_WIDTH-1:0] b_eff;
    logic                 cin_eff;

    // Whole pipeline moves together; nothing advances while the output is blocked.
    assign in_ready = out_ready || !out_valid;
    assign advance  = in_ready;
    assign b_eff    = (mode == OP_SUB) ? ~b : b;
    assign cin_eff  = eff_carry_in(mode, carry_in);

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * CHUNK;
        localparam int HI = (gi + 1) * CHUNK;

        logic             vld_reg;
        logic             cy_reg;
        logic [HI-1:0]    sum_reg;
        logic             vld_src;
        logic             cin_chunk;
        logic [CHUNK-1:0] a_chunk;
        logic [CHUNK-1:0] b_chunk;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_cout;
        logic             chunk_msb_cin;
        logic [HI-1:0]    sum_next;

        if (gi == 0) begin : g_src
            assign vld_src   = in_valid;
            assign a_chunk   = a[CHUNK-1:0];
            assign b_chunk   = b_eff[CHUNK-1:0];
            assign cin_chunk = cin_eff;
            assign sum_next  = chunk_sum;
        end else begin : g_src
            assign vld_src   = g_stage[gi-1].vld_reg;
            assign a_chunk   = g_stage[gi-1].g_skew.a_reg[LO +: CHUNK];
            assign b_chunk   = g_stage[gi-1].g_skew.b_reg[LO +: CHUNK];
            assign cin_chunk = g_stage[gi-1].cy_reg;
            assign sum_next  = {chunk_sum, g_stage[gi-1].sum_reg};
        end

        adder_nbit #(.BIT_WIDTH(CHUNK)) u_chunk_add (
            .a            (a_chunk),
            .b            (b_chunk),
            .carry_in     (cin_chunk),
            .sum          (chunk_sum),
            .carry_out    (chunk_cout),
            .msb_carry_in (chunk_msb_cin)
        );

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                vld_reg <= 1'b0;
                cy_reg  <= 1'b0;
                sum_reg <= '0;
            end else if (advance) begin
                vld_reg <= vld_src;
                cy_reg  <= chunk_cout;
                sum_reg <= sum_next;
            end
        end

        if (gi < STAGES - 1) begin : g_skew
            // Only the chunks still waiting for their turn are carried forward.
            logic [BIT_WIDTH-1:HI] a_reg;
            logic [BIT_WIDTH-1:HI] b_reg;
            logic [BIT_WIDTH-1:HI] a_up;
            logic [BIT_WIDTH-1:HI] b_up;

            if (gi == 0) begin : g_up
                assign a_up = a[BIT_WIDTH-1:HI];
                assign b_up = b_eff[BIT_WIDTH-1:HI];
            end else begin : g_up
                assign a_up = g_stage[gi-1].g_skew.a_reg[BIT_WIDTH-1:HI];
                assign b_up = g_stage[gi-1].g_skew.b_reg[BIT_WIDTH-1:HI];
            end

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (advance) begin
                    a_reg <= a_up;
                    b_reg <= b_up;
                end
            end
        end else begin : g_last
            logic msb_cin_reg;

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    msb_cin_reg <= 1'b0;
                end else if (advance) begin
                    msb_cin_reg <= chunk_msb_cin;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_reg;
    assign sum       = g_stage[STAGES-1].sum_reg;
    assign carry_out = g_stage[STAGES-1].cy_reg;
    assign overflow  = g_stage[STAGES-1].g_last.msb_cin_reg ^ g_stage[STAGES-1].cy_reg;

    a_operands_known: assert property (
        @(posedge clk) disable iff (!n_rst)
        in_valid |-> !$isunknown({a, b, mode})
    );

    a_valid_held_in_stall: assert property (
        @(posedge clk) disable iff (!n_rst)
        (out_valid && !out_ready) |=> out_valid
    );

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// Randomised and directed check of adder_pipelined_nbit across four
// width/depth configurations against an arithmetic reference model.
module tb_adder_pipelined_nbit;
    import adder_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        cin_drv;
    op_t         mode_drv;
    int          cfg;

    logic [3:0]  iv;
    logic [3:0]  ir;
    logic [3:0]  ovl;
    logic [3:0]  co;
    logic [3:0]  of;
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [31:0] sum2;
    logic [11:0] sum3;

    logic        cur_in_ready;
    logic        cur_out_valid;
    logic [31:0] cur_sum;
    logic        cur_cout;
    logic        cur_ovf;
    int          cur_w;
    int          cur_s;

    int          total = 0;
    int          bad = 0;
    int          valid_seen = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_iv
        assign iv[gi] = in_valid && (cfg == gi);
    end

    adder_pipelined_nbit #(.BIT_WIDTH(16), .NUM_STAGES(4)) dut0 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .carry_in(cin_drv), .mode(mode_drv),
        .out_valid(ovl[0]), .out_ready(out_ready), .sum(sum0),
        .carry_out(co[0]), .overflow(of[0]));

    adder_pipelined_nbit #(.BIT_WIDTH(8), .NUM_STAGES(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .carry_in(cin_drv), .mode(mode_drv),
        .out_valid(ovl[1]), .out_ready(out_ready), .sum(sum1),
        .carry_out(co[1]), .overflow(of[1]));

    adder_pipelined_nbit #(.BIT_WIDTH(32), .NUM_STAGES(8)) dut2 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_drv), .b(b_drv), .carry_in(cin_drv), .mode(mode_drv),
        .out_valid(ovl[2]), .out_ready(out_ready), .sum(sum2),
        .carry_out(co[2]), .overflow(of[2]));

    adder_pipelined_nbit #(.BIT_WIDTH(12), .NUM_STAGES(3)) dut3 (
        .clk(clk), .n_rst(n_rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_drv[11:0]), .b(b_drv[11:0]), .carry_in(cin_drv), .mode(mode_drv),
        .out_valid(ovl[3]), .out_ready(out_ready), .sum(sum3),
        .carry_out(co[3]), .overflow(of[3]));

    always_comb begin
        cur_in_ready  = ir[0];
        cur_out_valid = ovl[0];
        cur_cout      = co[0];
        cur_ovf       = of[0];
        cur_sum       = {16'b0, sum0};
        cur_w         = 16;
        cur_s         = 4;
        case (cfg)
            1: begin
                cur_in_ready = ir[1]; cur_out_valid = ovl[1]; cur_cout = co[1];
                cur_ovf = of[1]; cur_sum = {24'b0, sum1}; cur_w = 8; cur_s = 1;
            end
            2: begin
                cur_in_ready = ir[2]; cur_out_valid = ovl[2]; cur_cout = co[2];
                cur_ovf = of[2]; cur_sum = sum2; cur_w = 32; cur_s = 8;
            end
            3: begin
                cur_in_ready = ir[3]; cur_out_valid = ovl[3]; cur_cout = co[3];
                cur_ovf = of[3]; cur_sum = {20'b0, sum3}; cur_w = 12; cur_s = 3;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cfg=%0d t=%0t)", tag, got, exp, cfg, $time);
        end
    endtask

    // Plain integer arithmetic: {overflow, carry_out, sum}.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic cin, input logic sub);
        longint unsigned mask, x, y, c, full, s, cy, ov;
        mask = (64'd1 << w) - 1;
        x    = {32'b0, av} & mask;
        y    = (sub ? ~{32'b0, bv} : {32'b0, bv}) & mask;
        c    = sub ? 64'd1 : {63'b0, cin};
        full = x + y + c;
        s    = full & mask;
        cy   = (full >> w) & 64'd1;
        ov   = (((x ^ s) & (y ^ s)) >> (w - 1)) & 64'd1;
        return {ov[0], cy[0], s[31:0]};
    endfunction

    // Result scoreboard plus stall-stability watcher.
    logic        stalled_prev = 1'b0;
    logic [33:0] snap;
    always @(negedge clk) begin
        if (stalled_prev) begin
            check("stall_valid", {63'b0, cur_out_valid}, 64'd1);
            check("stall_hold", {30'b0, cur_ovf, cur_cout, cur_sum}, {30'b0, snap});
        end
        stalled_prev = n_rst && cur_out_valid && !out_ready;
        snap = {cur_ovf, cur_cout, cur_sum};
        if (stalled_prev)
            check("stall_in_ready", {63'b0, cur_in_ready}, 64'd0);
        if (n_rst && cur_out_valid && out_ready) begin
            logic [33:0] e;
            valid_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("result cfg=%0d sum=%0h cout=%0b ovf=%0b exp_sum=%0h", cfg,
                         cur_sum, cur_cout, cur_ovf, e[31:0]);
                check("sum", {32'b0, cur_sum}, {32'b0, e[31:0]});
                check("carry_out", {63'b0, cur_cout}, {63'b0, e[32]});
                check("overflow", {63'b0, cur_ovf}, {63'b0, e[33]});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cin, input logic sub);
        a_drv = av; b_drv = bv; cin_drv = cin;
        mode_drv = sub ? OP_SUB : OP_ADD;
        in_valid = 1'b1;
        #1;
        for (int t = 0; t < 100 && !cur_in_ready; t++) begin
            @(posedge clk); #2;
        end
        if (!cur_in_ready) check("accept_timeout", 64'd0, 64'd1);
        else exp_q.push_back(model(cur_w, av, bv, cin, sub));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 64'd0);
    endtask

    task automatic check_latency();
        int n;
        drain();
        send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        n = 1;
        while (!cur_out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, cur_s);
        drain();
    endtask

    task automatic directed();
        logic [63:0] ones, maxpos, minneg;
        ones   = (64'd1 << cur_w) - 1;
        maxpos = (64'd1 << (cur_w - 1)) - 1;
        minneg = 64'd1 << (cur_w - 1);
        send(ones[31:0], 32'd1, 1'b0, 1'b0);
        send(maxpos[31:0], 32'd1, 1'b0, 1'b0);
        send(minneg[31:0], 32'd1, 1'b0, 1'b1);
        send(32'd3, 32'd5, 1'b1, 1'b1);
        drain();
    endtask

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg = 0;
        a_drv = '0; b_drv = '0; cin_drv = 1'b0; mode_drv = OP_ADD;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {60'b0, ovl}, 64'd0);
        check("rst_sum", {32'b0, cur_sum}, 64'd0);
        check("rst_flags", {60'b0, co | of}, 64'd0);
        check("rst_in_ready", {60'b0, ir}, 64'hF);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Directed edge cases plus random traffic and latency in every configuration.
        for (int c = 0; c < 4; c++) begin
            cfg = c;
            #1;
            directed();
            for (int i = 0; i < 12; i++)
                send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain();
            check_latency();
        end

        // 20-op stream with a 5-cycle output stall in the middle.
        cfg = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with a valid result at the output and more ops behind it.
        send(32'h1234, 32'h1111, 1'b0, 1'b0);
        send(32'h2222, 32'h0101, 1'b0, 1'b0);
        send(32'h3333, 32'h0001, 1'b0, 1'b1);
        send(32'h4444, 32'h0404, 1'b0, 1'b0);
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", {63'b0, cur_out_valid}, 64'd0);
        check("midrst_sum", {32'b0, cur_sum}, 64'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        valid_seen = 0;
        repeat (12) @(posedge clk);
        #1;
        check("post_reset_idle", valid_seen, 64'd0);
        send(32'hFFFF, 32'h0001, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
